// File: rtl/mix_pkg.sv
// Shared types and constants for the 8-lane, 32-bit mixing datapath and its round sequencer.
package mix_pkg;

  localparam int LANES     = 8;
  localparam int RND_W_DEF = 16;

  typedef logic [31:0]           lane_t;
  typedef lane_t [LANES-1:0]     state_t;

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} stage_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  localparam lane_t M6 [LANES] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam lane_t A6 [LANES] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam lane_t M7 [LANES] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam lane_t A7 [LANES] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

  // Power-on lane contents: each lane holds its own index.
  function automatic state_t reset_state();
    state_t s;
    for (int i = 0; i < LANES; i++) s[i] = lane_t'(i);
    return s;
  endfunction

endpackage

// File: rtl/mix_stage_comb.sv
// One mixing stage as pure combinational logic; lanes update in order 0..7 and each
// lane sees the already-updated values of lower lanes within the same stage.
module mix_stage_comb
  import mix_pkg::*;
(
  input  state_t state_in,
  input  stage_e stage,
  output state_t state_out
);

  always_comb begin
    state_t t;
    t = state_in;
    for (int i = 0; i < LANES; i++) begin
      // 3-bit casts give the mod-8 lane wrap for free
      unique case (stage)
        S0: t[3'(i)] = t[3'(i)] + lane_t'(i);
        S1: t[3'(i)] = t[3'(i)] + t[3'(i + 7)];
        S2: t[3'(i)] = t[3'(i)] + t[3'(i + 1)] - t[3'(i + 5)];
        S3: t[3'(i)] = t[3'(i)] ^ (t[3'(i + 3)] << 16);
        S4: t[3'(i)] = t[3'(i)] - (t[3'(i + 2)] >> 17) + (t[3'(i + 4)] >> 12);
        S5: t[3'(i)] = t[3'(i)] + t[3'(i + 7)] - t[3'(i + 6)];
        S6: t[3'(i)] = t[3'(i)] * M6[i] + A6[i];
        default: t[3'(i)] = t[3'(i)] * M7[i] + A7[i];
      endcase
    end
    state_out = t;
  end

endmodule

// File: rtl/mix_round_sequencer.sv
// Multi-cycle round sequencer: one mixing stage per clock, each stage applied twice per round.
// Define MIX_ABORT_EN to add the abort input and aborted status output.
//
// state | meaning
// IDLE  | waiting; seed loads and start accepted here
// RUN   | applying one stage per cycle, 16 steps per round
// DONE  | one-cycle completion pulse, then back to IDLE
module mix_round_sequencer
  import mix_pkg::*;
#(
  parameter int RND_W = RND_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [RND_W-1:0] rounds,
  input  logic             load_en,
  input  logic [2:0]       load_idx,
  input  logic [31:0]      load_data,
  input  logic [2:0]       rd_idx,
`ifdef MIX_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [31:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic [3:0]       step_cnt,
  output logic [RND_W-1:0] round_cnt
);

  fsm_e             state_q, state_d;
  state_t           o_q, o_d, stage_out;
  stage_e           stage_sel;
  logic [3:0]       step_q, step_d;
  logic [RND_W-1:0] rnd_q, rnd_d, rounds_q, rounds_d;
  logic             abort_req;

`ifdef MIX_ABORT_EN
  logic accept;

  assign abort_req = abort;
  assign accept    = (state_q == IDLE) && start && !load_en;

  always_ff @(posedge clk) begin
    if (!rst_n)                          aborted <= 1'b0;
    else if (accept)                     aborted <= 1'b0;
    else if ((state_q == RUN) && abort)  aborted <= 1'b1;
  end
`else
  assign abort_req = 1'b0;
`endif

  assign stage_sel = stage_e'(step_q[3:1]);

  mix_stage_comb u_stage (
    .state_in  (o_q),
    .stage     (stage_sel),
    .state_out (stage_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      o_q      <= reset_state();
      step_q   <= '0;
      rnd_q    <= '0;
      rounds_q <= '0;
    end else begin
      state_q  <= state_d;
      o_q      <= o_d;
      step_q   <= step_d;
      rnd_q    <= rnd_d;
      rounds_q <= rounds_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    o_d      = o_q;
    step_d   = step_q;
    rnd_d    = rnd_q;
    rounds_d = rounds_q;
    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          o_d[load_idx] = load_data;
        end else if (start) begin
          if (rounds != '0) begin
            state_d  = RUN;
            rounds_d = rounds;
            step_d   = '0;
            rnd_d    = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort_req) begin
          state_d = DONE;
        end else begin
          o_d    = stage_out;
          step_d = step_q + 4'd1;
          if (step_q == 4'd15) begin
            rnd_d = rnd_q + RND_W'(1);
            if (rnd_d == rounds_q) state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_data   = o_q[rd_idx];
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign step_cnt  = step_q;
  assign round_cnt = rnd_q;

endmodule

// File: doc/mix_round_sequencer.md
Name: mix_round_sequencer

Overview:
- Iterative controller and state holder for the 8-lane, 32-bit mixing datapath.
- Holds the lane state o[0..7], accepts seed loads, and on `start` runs a programmed number of mixing rounds.
- Each clock cycle executes exactly one stage of a round, so the long serial chain becomes a multi-cycle schedule with a start/done handshake.
- Sits between a host/config port and any consumer of the mixed state.

Parameters:
- LANES, 8, number of 32-bit lanes; fixed, all index arithmetic is mod 8.
- RND_W, 16, width of the round-count field.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin run; sampled only in IDLE
- rounds  in  RND_W  round count, latched on accepted start
- load_en  in  1  write seed lane; honoured only in IDLE
- load_idx  in  3  lane to write
- load_data  in  32  seed value
- rd_idx  in  3  lane read select
- rd_data  out  32  o[rd_idx], combinational from the state register
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a run completes
- step_cnt  out  4  current step 0..15 within the round
- round_cnt  out  RND_W  rounds completed in the current run

Behaviour:
- Reset (clk edge with rst_n=0): o[i]=i (0..7), FSM=IDLE, busy=0, done=0, step_cnt=0, round_cnt=0. Reset mid-RUN aborts the run and discards the state.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1, rounds>0: latch rounds, go to RUN, step_cnt=0, round_cnt=0.
  - IDLE, start=1, rounds=0: go to DONE; state is unchanged.
  - RUN: each cycle applies stage S[step_cnt>>1] to the state, then increments step_cnt. Every stage is therefore applied twice consecutively, giving 16 steps per round.
    - At step 15, step_cnt wraps to 0 and round_cnt increments.
    - When round_cnt reaches the latched rounds, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge T; state is final at edge T+16R; done is high during cycle T+16R+1 (R=0: done high in the cycle after T).
- In IDLE, load_en has priority over start in the same cycle: the load is written and start is ignored.
- Outside IDLE, start and load_en are ignored.
- Stage semantics:
  - Within one stage, lanes update in order i=0..7. Each update sees lanes already updated earlier in that same stage (blocking-chain semantics).
  - All arithmetic is mod 2^32; shifts are logical. Indices are mod 8.
- Stage formulas:
  - S0: o[i] += i
  - S1: o[i] += o[i-1]
  - S2: o[i] = o[i] + o[i+1] - o[i+5]
  - S3: o[i] ^= (o[i+3] << 16)
  - S4: o[i] = o[i] - (o[i+2] >> 17) + (o[i+4] >> 12)
  - S5: o[i] = o[i] + o[i-1] - o[i-2]
  - S6: o[i] = o[i]*M6[i] + A6[i]; M6={2,3,5,7,11,13,17,19}, A6={3,5,7,11,13,17,19,23}
  - S7: o[i] = o[i]*M7[i] + A7[i]; M7={2,3,3,3,5,13,35,87}, A7={0,1,8,27,64,125,216,343}
- round_cnt wraps naturally in RND_W bits; since rounds ≤ 2^RND_W-1, termination is exact.

Optional Feature:
- Macro: MIX_ABORT_EN.
- Defined: adds input `abort` (1 bit).
  - abort=1 in RUN: go to DONE next edge; the stage for that cycle is not applied; the partial state is retained.
  - done pulses as normal, and an extra output `aborted` (1 bit) is high alongside done.
  - `aborted` clears when the next run is accepted or on reset.
- Not defined: no abort or aborted ports; runs always complete.

Decomposition:
- Shared package mix_pkg holds:
  - lane_t (32-bit) and state_t (array of 8 lane_t)
  - stage_e (S0..S7) and fsm_e (IDLE/RUN/DONE)
  - constant arrays M6, A6, M7, A7
- Sub-module mix_stage_comb: purely combinational, state_t in + stage_e → state_t out, implementing the chained per-stage update. It is shared with the golden model in the bench.

Test Plan:
- Reset, then read each lane → rd_data[i]=i; busy=0, done=0.
- Start rounds=1 from reset state; read lane 7 after 2 RUN cycles → 21 (S0 applied twice gives o[i]=3i); busy high for 16 cycles, then done pulses for 1 cycle; all lanes match the golden model.
- Load o[0..7]=32'hFFFF_FFFF, start rounds=3 → done 49 cycles after start acceptance; lanes match the golden model, which exercises wrap-around.
- Start rounds=0 → done in the next cycle, busy never asserted, state unchanged; start and load_en asserted during a rounds=2 run → both ignored, result equals the uninterrupted run.
- rst_n=0 at step 7 of round 0 → next cycle busy=0, o[i]=i; a fresh start with rounds=1 gives the same result as the test-2 run.
- (MIX_ABORT_EN) abort at step 5 → done and aborted both high; state equals the golden model after exactly 5 steps.
